// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter, instruction register and fetch bookkeeping
module fetch_pc_unit #(
   parameter int           WIDTH       = 16,
   parameter logic [4:0]   ILLEGAL_MIN = 5'b10100
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [WIDTH-1:0] MemOut,
   input  logic [WIDTH-1:0] ALUResult,
   input  logic             Zero,
   input  logic [1:0]       PCSrc,
   input  logic [1:0]       PCWrite,
   input  logic [1:0]       Branch,
   input  logic [1:0]       BneOrBeq,
   input  logic             IRWrite,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] OldPC,
   output logic [WIDTH-1:0] ALUOut,
   output logic [4:0]       Opcode,
   output logic [WIDTH-1:0] Imm,
   output logic [WIDTH-1:0] ImmZ,
   output logic [15:0]      InstrCount,
   output logic [7:0]       TakenCount,
   output logic             IllegalOp
);

   logic [WIDTH-1:0] ir;
   logic [WIDTH-1:0] next_pc;
   logic             pc_write;
   logic             taken;
   logic             branch_load;
   logic [4:0]       fetch_opcode;
   logic             fetch_illegal;

   assign pc_write      = |PCWrite;
   assign taken         = (|Branch) && (BneOrBeq[0] ? Zero : !Zero);
   // an unconditional write always wins over a branch in the same cycle
   assign branch_load   = !pc_write && taken;
   assign fetch_opcode  = MemOut[15:11];
   assign fetch_illegal = (fetch_opcode == 5'd0) || (fetch_opcode >= ILLEGAL_MIN);

   // instruction-word fields decoded straight from IR
   assign Opcode = ir[15:11];
   assign Imm    = {{(WIDTH-11){ir[10]}}, ir[10:0]};
   assign ImmZ   = {{(WIDTH-11){1'b0}}, ir[10:0]};

   // next-PC source mux; select 3 keeps the current PC
   always_comb begin
      next_pc = PC;
      case (PCSrc)
         2'd0:    next_pc = ALUResult;
         2'd1:    next_pc = {OldPC[WIDTH-1:11], ir[10:0]};
         2'd2:    next_pc = ALUOut;
         default: next_pc = PC;
      endcase
   end

   // ALU result pipeline register, loaded every cycle
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) ALUOut <= '0;
      else        ALUOut <= ALUResult;
   end

   // program counter: unconditional write first, then taken branch to ALUOut
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)           PC <= '0;
      else if (pc_write)    PC <= next_pc;
      else if (branch_load) PC <= ALUOut;
   end

   // IR captures the fetched word together with the address it came from
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         ir    <= '0;
         OldPC <= '0;
      end else if (IRWrite) begin
         ir    <= MemOut;
         OldPC <= PC;
      end
   end

   // fetch counter wraps; illegal-opcode flag is sticky until reset
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         InstrCount <= '0;
         IllegalOp  <= 1'b0;
      end else if (IRWrite) begin
         InstrCount <= InstrCount + 16'd1;
         if (fetch_illegal) IllegalOp <= 1'b1;
      end
   end

   // taken-branch counter saturates at its maximum
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)                                 TakenCount <= '0;
      else if (branch_load && TakenCount != 8'hFF) TakenCount <= TakenCount + 8'd1;
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;

   localparam int WIDTH = 16;

   logic             CLK = 1'b0;
   logic             Reset;
   logic [WIDTH-1:0] MemOut, ALUResult;
   logic             Zero;
   logic [1:0]       PCSrc, PCWrite, Branch, BneOrBeq;
   logic             IRWrite;
   logic [WIDTH-1:0] PC, OldPC, ALUOut, Imm, ImmZ;
   logic [4:0]       Opcode;
   logic [15:0]      InstrCount;
   logic [7:0]       TakenCount;
   logic             IllegalOp;

   fetch_pc_unit #(.WIDTH(WIDTH), .ILLEGAL_MIN(5'b10100)) dut (
      .CLK(CLK), .Reset(Reset), .MemOut(MemOut), .ALUResult(ALUResult), .Zero(Zero),
      .PCSrc(PCSrc), .PCWrite(PCWrite), .Branch(Branch), .BneOrBeq(BneOrBeq),
      .IRWrite(IRWrite), .PC(PC), .OldPC(OldPC), .ALUOut(ALUOut), .Opcode(Opcode),
      .Imm(Imm), .ImmZ(ImmZ), .InstrCount(InstrCount), .TakenCount(TakenCount),
      .IllegalOp(IllegalOp)
   );

   always #5 CLK = ~CLK;

   typedef enum int {F_PC, F_OLDPC, F_ALUOUT, F_OPC, F_IMM, F_IMMZ, F_IC, F_TC, F_ILL} field_t;
   typedef struct {
      string       tag;
      field_t      fld;
      logic [15:0] exp;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [15:0] get_field(field_t f);
      case (f)
         F_PC:     return PC;
         F_OLDPC:  return OldPC;
         F_ALUOUT: return ALUOut;
         F_OPC:    return {11'd0, Opcode};
         F_IMM:    return Imm;
         F_IMMZ:   return ImmZ;
         F_IC:     return InstrCount;
         F_TC:     return {8'd0, TakenCount};
         default:  return {15'd0, IllegalOp};
      endcase
   endfunction

   task automatic expect_val(input string tag, input field_t f, input logic [15:0] v);
      sb_entry_t e;
      e.tag = tag;
      e.fld = f;
      e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic check_all();
      sb_entry_t e;
      logic [15:0] obs;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         obs = get_field(e.fld);
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic expect_all_zero(input string tag);
      expect_val({tag, "_pc"},  F_PC, 16'h0);
      expect_val({tag, "_old"}, F_OLDPC, 16'h0);
      expect_val({tag, "_alu"}, F_ALUOUT, 16'h0);
      expect_val({tag, "_opc"}, F_OPC, 16'h0);
      expect_val({tag, "_imm"}, F_IMM, 16'h0);
      expect_val({tag, "_ic"},  F_IC, 16'h0);
      expect_val({tag, "_tc"},  F_TC, 16'h0);
      expect_val({tag, "_ill"}, F_ILL, 16'h0);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      MemOut = '0; ALUResult = '0; Zero = 1'b0; PCSrc = 2'd0;
      PCWrite = 2'd0; Branch = 2'd0; BneOrBeq = 2'd0; IRWrite = 1'b0;
   endtask

   initial begin
      Reset = 1'b0;
      idle_inputs();
      #2;
      expect_all_zero("reset");
      check_all();

      // edges while held in reset must not update anything
      MemOut = 16'h0805; ALUResult = 16'h0001; PCWrite = 2'd1; IRWrite = 1'b1;
      expect_all_zero("in_reset");
      step();

      // first fetch
      Reset = 1'b1;
      expect_val("f1_pc", F_PC, 16'h0001);
      expect_val("f1_old", F_OLDPC, 16'h0000);
      expect_val("f1_opc", F_OPC, 16'h0001);
      expect_val("f1_imm", F_IMM, 16'h0005);
      expect_val("f1_immz", F_IMMZ, 16'h0005);
      expect_val("f1_ic", F_IC, 16'h0001);
      expect_val("f1_alu", F_ALUOUT, 16'h0001);
      expect_val("f1_ill", F_ILL, 16'h0000);
      step();

      // set PC to 0x1234
      IRWrite = 1'b0; ALUResult = 16'h1234;
      expect_val("set_pc", F_PC, 16'h1234);
      expect_val("set_ic", F_IC, 16'h0001);
      step();

      // fetch jump instruction from 0x1234
      IRWrite = 1'b1; MemOut = 16'h47FF; PCWrite = 2'd0; ALUResult = 16'h0000;
      expect_val("j_old", F_OLDPC, 16'h1234);
      expect_val("j_pc_hold", F_PC, 16'h1234);
      expect_val("j_opc", F_OPC, 16'h0008);
      expect_val("j_imm", F_IMM, 16'hFFFF);
      expect_val("j_immz", F_IMMZ, 16'h07FF);
      expect_val("j_ic", F_IC, 16'h0002);
      step();

      // jump target
      IRWrite = 1'b0; PCSrc = 2'd1; PCWrite = 2'd1;
      expect_val("jump_pc", F_PC, 16'h17FF);
      step();

      // PCSrc 3 holds even with write enabled
      PCSrc = 2'd3; PCWrite = 2'd2; ALUResult = 16'h0300;
      expect_val("hold_pc", F_PC, 16'h17FF);
      expect_val("hold_alu", F_ALUOUT, 16'h0300);
      step();

      // PCSrc 2 selects ALUOut
      PCSrc = 2'd2; PCWrite = 2'd1; ALUResult = 16'h0040;
      expect_val("src2_pc", F_PC, 16'h0300);
      step();

      // beq taken to ALUOut=0x0040, PCSrc is irrelevant
      PCWrite = 2'd0; PCSrc = 2'd3; Branch = 2'd1; BneOrBeq = 2'd1; Zero = 1'b1; ALUResult = 16'h0050;
      expect_val("beq_pc", F_PC, 16'h0040);
      expect_val("beq_tc", F_TC, 16'h0001);
      step();

      // beq not taken
      Zero = 1'b0; ALUResult = 16'h0060;
      expect_val("beq_nt_pc", F_PC, 16'h0040);
      expect_val("beq_nt_tc", F_TC, 16'h0001);
      step();

      // bne taken, BneOrBeq bit1 ignored
      Branch = 2'd2; BneOrBeq = 2'd2; Zero = 1'b0; ALUResult = 16'h0070;
      expect_val("bne_pc", F_PC, 16'h0060);
      expect_val("bne_tc", F_TC, 16'h0002);
      step();

      // PCWrite alongside Branch
      Branch = 2'd1; BneOrBeq = 2'd0; Zero = 1'b1; PCWrite = 2'd1; PCSrc = 2'd0; ALUResult = 16'h0099;
      expect_val("pri_pc", F_PC, 16'h0099);
      expect_val("pri_tc", F_TC, 16'h0002);
      step();

      // PCWrite overrides a branch whose condition holds
      BneOrBeq = 2'd1; PCWrite = 2'd2; ALUResult = 16'h00AA;
      expect_val("pri2_pc", F_PC, 16'h00AA);
      expect_val("pri2_tc", F_TC, 16'h0002);
      step();

      // saturate the taken counter
      PCWrite = 2'd0;
      for (int i = 0; i < 260; i++) begin
         ALUResult = 16'(i);
         if (i == 252) expect_val("tc_reach", F_TC, 16'h00FF);
         if (i == 259) expect_val("tc_sat", F_TC, 16'h00FF);
         step();
      end

      // illegal opcode 20 sets the sticky flag
      Branch = 2'd0; IRWrite = 1'b1; MemOut = 16'hA000;
      expect_val("ill_opc", F_OPC, 16'h0014);
      expect_val("ill_set", F_ILL, 16'h0001);
      step();
      MemOut = 16'h0805;
      expect_val("ill_sticky", F_ILL, 16'h0001);
      expect_val("ill_opc2", F_OPC, 16'h0001);
      step();

      // asynchronous reset mid-cycle
      #3;
      Reset = 1'b0;
      #1;
      expect_all_zero("async");
      check_all();

      // held in reset across an edge with fetch requested
      PCWrite = 2'd1; ALUResult = 16'h0123; MemOut = 16'h9800;
      expect_val("held_pc", F_PC, 16'h0000);
      expect_val("held_ic", F_IC, 16'h0000);
      step();

      // release: fetch from address 0, opcode 19 is legal
      Reset = 1'b1;
      expect_val("rel_old", F_OLDPC, 16'h0000);
      expect_val("rel_pc", F_PC, 16'h0123);
      expect_val("rel_ic", F_IC, 16'h0001);
      expect_val("op19_ill", F_ILL, 16'h0000);
      expect_val("op19_opc", F_OPC, 16'h0013);
      step();

      // opcode 0 is illegal
      PCWrite = 2'd0; MemOut = 16'h0000;
      expect_val("op0_ill", F_ILL, 16'h0001);
      expect_val("op0_old", F_OLDPC, 16'h0123);
      step();

      // instruction counter wrap
      Reset = 1'b0;
      #1;
      Reset = 1'b1;
      MemOut = 16'h0805;
      for (int i = 0; i < 65536; i++) begin
         if (i == 65534) expect_val("ic_max", F_IC, 16'hFFFF);
         if (i == 65535) expect_val("ic_wrap", F_IC, 16'h0000);
         step();
      end

      idle_inputs();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter: WIDTH, 16, datapath, PC, IR and memory word width.
REQ-002 Parameter: ILLEGAL_MIN, 5'b10100, lowest opcode value the control sequencer does not decode.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 MemOut  in  WIDTH  memory read data, the instruction word during Fetch.
REQ-006 ALUResult  in  WIDTH  combinational ALU result.
REQ-007 Zero  in  1  ALU result == 0.
REQ-008 PCSrc  in  2  PC source select from the control sequencer.
REQ-009 PCWrite  in  2  unconditional PC write; any nonzero value = write.
REQ-010 Branch  in  2  conditional PC write; any nonzero value = branch.
REQ-011 BneOrBeq  in  2  bit0 = 1 branch on Zero (beq), 0 branch on !Zero (bne); bit1 ignored.
REQ-012 IRWrite  in  1  load instruction register.
REQ-013 PC  out  WIDTH  current program counter.
REQ-014 OldPC  out  WIDTH  address of the instruction held in IR.
REQ-015 ALUOut  out  WIDTH  ALUResult registered every cycle.
REQ-016 Opcode  out  5  IR[15:11], to the control sequencer.
REQ-017 Imm  out  WIDTH  IR[10:0] sign-extended to WIDTH.
REQ-018 ImmZ  out  WIDTH  IR[10:0] zero-extended to WIDTH.
REQ-019 InstrCount  out  16  instructions fetched.
REQ-020 TakenCount  out  8  branches taken.
REQ-021 IllegalOp  out  1  sticky illegal-opcode flag.

Function
REQ-022 IR SHALL load MemOut on a rising edge with IRWrite=1; otherwise hold.
REQ-023 OldPC SHALL load the pre-update PC on the same edge IR loads.
REQ-024 ALUOut SHALL load ALUResult on every rising edge, giving 1-cycle latency.
REQ-025 Next-PC select: PCSrc 0 -> ALUResult; 1 -> {OldPC[WIDTH-1:11], IR[10:0]}; 2 -> ALUOut; 3 -> hold PC.
REQ-026 Condition: taken = (Branch != 0) and (BneOrBeq[0] ? Zero : !Zero).
REQ-027 PC SHALL load the selected next-PC when PCWrite != 0.
REQ-028 PC SHALL load ALUOut when PCWrite == 0 and taken, regardless of PCSrc.
REQ-029 When PCWrite != 0 and Branch != 0 in the same cycle, PCWrite SHALL take priority, and TakenCount SHALL NOT increment.
REQ-030 PC arithmetic SHALL wrap modulo 2^WIDTH; no overflow detection.
REQ-031 InstrCount SHALL increment by 1 on each IRWrite edge and wrap 0xFFFF -> 0x0000.
REQ-032 TakenCount SHALL increment on each edge where a branch-taken PC load occurs, saturating at 255.
REQ-033 IllegalOp SHALL be set on an IRWrite edge when MemOut[15:11] == 0 or >= ILLEGAL_MIN; it stays set until reset.
REQ-034 Opcode, Imm and ImmZ SHALL be purely combinational from IR and change only after an IR load.
REQ-035 PC SHALL be fetch-phase sequenced by the control FSM; no internal state machine beyond the registers above.

Reset
REQ-036 While Reset=0, the unit SHALL immediately, without a clock, clear PC, OldPC, IR, ALUOut, InstrCount, TakenCount and IllegalOp to 0.
REQ-037 A reset asserted mid-instruction SHALL discard the in-flight IR; the first edge after release with IRWrite=1 fetches from address 0.
REQ-038 Reset deassertion SHALL take effect on the following clock edge; no update occurs on the releasing edge if Reset is still low at that edge.

Verification
REQ-039 Reset low, then release; Fetch cycle with MemOut=0x0805 and ALUResult=0x0001, PCSrc=0, PCWrite=1, IRWrite=1 -> PC=0x0001, OldPC=0x0000, Opcode=1, Imm=0x0005, InstrCount=1.
REQ-040 IR=0x47FF (Jump) with OldPC=0x1234; PCSrc=1, PCWrite=1 -> PC=0x17FF, Imm=0xFFFF, ImmZ=0x07FF.
REQ-041 ALUOut=0x0040; Branch=1, BneOrBeq=1, Zero=1 -> PC=0x0040, TakenCount+1; repeat with Zero=0 -> PC unchanged.
REQ-042 Branch=1, BneOrBeq=0, Zero=1 together with PCWrite=1, PCSrc=0, ALUResult=0x0099 -> PC=0x0099, TakenCount unchanged.
REQ-043 Force 260 taken branches -> TakenCount=255; fetch 65536 instructions -> InstrCount=0.
REQ-044 Fetch MemOut=0xA000 (opcode 20) -> IllegalOp=1, held across later legal fetches; assert Reset=0 mid-cycle -> all outputs 0 before the next CLK edge.
